uart_tx_serializer: RTL

- Parallel-to-serial UART transmitter (8N1, LSB first): the drive side of the serial link whose receive side is built from synchronous-reset capture registers.
- Accepts one byte per `tx_start` request, then shifts it out as start bit, 8 data bits and stop bit, each held for a fixed number of clock cycles.
- Sits between the system control logic and the board TX pin.
- Reports busy and completion status to the requester.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_serializer_if.sv | 18 +
 rtl/uart_baud_counter.sv | 35 +++
 rtl/uart_tx_serializer.sv | 108 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared UART state encoding, defaults and clog2 helper.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam int CLKS_PER_BIT_DEF = 10417;
  localparam int DATA_BITS_DEF    = 8;

  // Width able to hold 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if (((value - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_serializer_if : requester <-> transmitter handshake and TX line. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx;

  modport master (output tx_data, tx_start, input tx_busy, tx_done, tx);
  modport slave  (input tx_data, tx_start, output tx_busy, tx_done, tx);
endinterface
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_counter : 0..CLKS_PER_BIT-1 counter, tick on terminal count.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  wire logic                             clk,
  input  wire logic                             rst,
  input  wire logic                             clear,
  input  wire logic                             enable,
  output logic                                  tick,
  output logic [clog2(CLKS_PER_BIT)-1:0]        count
);
  localparam int CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= (count_q == c_last) ? '0 : count_q + 1'b1;
    end
  end

  assign tick  = enable && (count_q == c_last);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_serializer : 8N1 LSB-first UART transmitter, registered outputs. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input wire logic          clk,
  input wire logic          rst,
  uart_tx_serializer_if.slave tx_if
);
  localparam int CW = clog2(CLKS_PER_BIT);
  localparam int IW = clog2(DATA_BITS);
  localparam logic [IW-1:0] c_last_bit = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0] c_pre_last = CW'(CLKS_PER_BIT - 2);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 w_accept;
  logic                 w_tick;
  logic [CW-1:0]        w_count;

  assign w_accept = (state_q == ST_IDLE) && tx_if.tx_start;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_accept),
    .enable (state_q != ST_IDLE),
    .tick   (w_tick),
    .count  (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          shift_d = tx_if.tx_data;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == c_last_bit) state_d = ST_STOP;
        end
      end
      default: begin
        if (w_tick) state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the upcoming state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (w_count == c_pre_last);
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_if.tx      = tx_q;
  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;

endmodule
`default_nettype wire
